keyword_nest_checker: RTL and testbench
=======================================

# keyword_nest_checker

Streaming, case-insensitive checker for `begin`/`end` keyword nesting over an 8-bit ASCII character stream, one character per accepted cycle. It replaces the fixed two-level balance checker with a parametrised nesting-depth counter, an input valid strobe, a synchronous clear, and sticky underflow/overflow flags. It sits on the character-input path next to the other text-scanning FSMs and drives the pass/fail `result` line plus diagnostic depth.

## Interface
- `DEPTH_W`, default 4: width of the nesting counter. Maximum legal depth is 2^DEPTH_W − 1.
- `clk` input 1: sole clock, rising-edge.
- `reset` input 1: asynchronous, active-low (0 = reset). All state clears immediately on assertion.
- `clear` input 1: synchronous clear, same effect as reset, applied at the clock edge.
- `in_valid` input 1: `in` is consumed at the edge only when 1. Otherwise all state holds.
- `in` input 8: ASCII character.
- `result` output 1: 1 when the effective depth is 0, and neither error nor overflow is effective.
- `depth` output DEPTH_W: effective nesting depth.
- `error` output 1: effective underflow, meaning an `end` with no open `begin`.
- `overflow` output 1: effective overflow, meaning a `begin` at maximum depth.

## Operation
- Words are maximal runs of non-space characters. Space is 8'h20 only; every other byte, including tab and CR, is a word character.
- A word is a keyword only if the whole word equals `begin` or `end`, compared case-insensitively per letter.
  - `xbegin`, `ending` and `be gin` are not keywords.
- Word FSM states:
  - IDLE: at a word start.
  - B1–B4: matched `b`, `be`, `beg`, `begi`.
  - E1–E2: matched `e`, `en`.
  - KB: full `begin` matched, pending.
  - KE: full `end` matched, pending.
  - SKIP: non-keyword word.
- Transitions on an accepted non-space character:
  - IDLE: b/B → B1; e/E → E1; anything else → SKIP.
  - Each partial state advances on the next expected letter, else → SKIP. B4 with n/N → KB. E2 with d/D → KE.
  - KB, KE, SKIP → SKIP. Leaving KB or KE this way retracts the pending keyword.
- Transition on an accepted space: every state → IDLE. Leaving KB or KE this way commits the keyword.
- Committed registers: `cnt` (DEPTH_W), `err_s`, `ovf_s`. `err_s` and `ovf_s` are sticky until reset or clear.
- Commit of `begin`:
  - cnt < max: cnt+1.
  - cnt = max: cnt unchanged, ovf_s ← 1.
- Commit of `end`:
  - cnt > 0: cnt−1.
  - cnt = 0: cnt unchanged, err_s ← 1.
- Effective outputs are combinational from registers only, with no path from `in`:
  - In KB: depth = cnt+1, saturating at max; overflow = ovf_s | (cnt==max).
  - In KE: depth = cnt−1, floored at 0; error = err_s | (cnt==0).
  - In all other states: depth = cnt, error = err_s, overflow = ovf_s.
  - result = (depth==0) & ~error & ~overflow.
- End of stream needs no terminator. A pending keyword is reflected in the outputs indefinitely.

## Timing
- Reset and clear state: FSM = IDLE, cnt = 0, err_s = 0, ovf_s = 0. Outputs: result = 1, depth = 0, error = 0, overflow = 0.
- Latency: outputs reflect an accepted character after the same rising edge, i.e. 1 cycle. A pending keyword shows immediately after its final letter is accepted.
- Retraction: the next accepted non-space character restores the outputs at that edge. Commit on space leaves the outputs unchanged.
- in_valid = 0 cycles are transparent. Pending state persists across them.
- clear = 1 with in_valid = 1: clear wins and the character is dropped.
- Reset deassertion is asynchronous to `clk`. The first accepted character is on the first edge with reset = 1.
- Reset asserted mid-word or while pending: everything clears, including sticky flags and the pending keyword.

## Test plan
- Reset, then stream "BEGIN eNd " with in_valid = 1 → after 'N': depth = 1, result = 0. After 'd': depth = 0, result = 1. Values hold through both spaces.
- "begins" → after 'n': depth = 1, result = 0. After 's': depth = 0, result = 1 (retracted). Also "xend " → error stays 0.
- DEPTH_W = 2, stream "begin " ×3 then "begin" → depth = 3, then overflow = 1 with depth = 3 and result = 0. Follow with "end " ×3 → depth = 0, overflow still 1, result = 0.
- "end" from reset → error = 1, result = 0. Then "x" → error = 0. Then " end " → err_s sticky, result = 0 until clear, after which result = 1.
- "be", hold in_valid = 0 for 5 cycles with in = 'x', then "gin" → depth = 1. Repeat with "b" then clear then "egin" → depth = 0, because "egin" is a SKIP word.
- Assert reset (0) asynchronously mid-cycle while in KB with depth = 2 → outputs go to result = 1, depth = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/keyword_nest_checker.sv
`default_nettype none
// ============================================================================
// Module  : keyword_nest_checker
// Brief   : Streaming case-insensitive begin/end nesting checker with
//           parametrised depth counter and sticky underflow/overflow flags.
// Revision: 1.0 - initial release
// ============================================================================
module keyword_nest_checker #(
    parameter int DEPTH_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic               error,
    output logic               overflow
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_B1   = 4'd1,
        S_B2   = 4'd2,
        S_B3   = 4'd3,
        S_B4   = 4'd4,
        S_E1   = 4'd5,
        S_E2   = 4'd6,
        S_KB   = 4'd7,
        S_KE   = 4'd8,
        S_SKIP = 4'd9
    } state_t;

    localparam logic [DEPTH_W-1:0] c_max  = {DEPTH_W{1'b1}};
    localparam logic [DEPTH_W-1:0] c_zero = {DEPTH_W{1'b0}};
    localparam logic [DEPTH_W-1:0] c_one  = {{(DEPTH_W-1){1'b0}}, 1'b1};

    state_t             r_state, w_state_nxt;
    logic [DEPTH_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_err, w_err_nxt;
    logic               r_ovf, w_ovf_nxt;
    logic [7:0]         w_lc;
    logic               w_is_space;

    // Fold upper-case letters only; other bytes pass through untouched.
    assign w_lc       = (in >= 8'h41 && in <= 8'h5a) ? (in | 8'h20) : in;
    assign w_is_space = (in == 8'h20);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= c_zero;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_cnt   <= c_zero;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_ovf_nxt   = r_ovf;
        if (in_valid) begin
            if (w_is_space) begin
                w_state_nxt = S_IDLE;
                if (r_state == S_KB) begin
                    if (r_cnt == c_max) w_ovf_nxt = 1'b1;
                    else                w_cnt_nxt = r_cnt + c_one;
                end else if (r_state == S_KE) begin
                    if (r_cnt == c_zero) w_err_nxt = 1'b1;
                    else                 w_cnt_nxt = r_cnt - c_one;
                end
            end else begin
                // Any miss drops into SKIP, which also retracts a pending keyword.
                w_state_nxt = S_SKIP;
                case (r_state)
                    S_IDLE: begin
                        if (w_lc == 8'h62)      w_state_nxt = S_B1;
                        else if (w_lc == 8'h65) w_state_nxt = S_E1;
                    end
                    S_B1: if (w_lc == 8'h65) w_state_nxt = S_B2;
                    S_B2: if (w_lc == 8'h67) w_state_nxt = S_B3;
                    S_B3: if (w_lc == 8'h69) w_state_nxt = S_B4;
                    S_B4: if (w_lc == 8'h6e) w_state_nxt = S_KB;
                    S_E1: if (w_lc == 8'h6e) w_state_nxt = S_E2;
                    S_E2: if (w_lc == 8'h64) w_state_nxt = S_KE;
                    default: w_state_nxt = S_SKIP;
                endcase
            end
        end
    end

    // Effective view: committed registers adjusted by any pending keyword.
    always_comb begin
        depth    = r_cnt;
        error    = r_err;
        overflow = r_ovf;
        if (r_state == S_KB) begin
            if (r_cnt == c_max) overflow = 1'b1;
            else                depth    = r_cnt + c_one;
        end else if (r_state == S_KE) begin
            if (r_cnt == c_zero) error = 1'b1;
            else                 depth = r_cnt - c_one;
        end
        result = (depth == c_zero) && !error && !overflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_keyword_nest_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_keyword_nest_checker
// Brief   : Scoreboard bench for keyword_nest_checker at DEPTH_W=4 and 2.
// Revision: 1.0 - initial release
// ============================================================================
module tb_keyword_nest_checker;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       in_valid;
    logic [7:0] in;

    logic       result0, error0, overflow0;
    logic [3:0] depth0;
    logic       result1, error1, overflow1;
    logic [1:0] depth1;

    keyword_nest_checker #(.DEPTH_W(4)) u_dut_w4 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in),
        .result(result0), .depth(depth0), .error(error0), .overflow(overflow0)
    );

    keyword_nest_checker #(.DEPTH_W(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in),
        .result(result1), .depth(depth1), .error(error1), .overflow(overflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] v0;
        logic [6:0] v1;
    } exp_t;

    exp_t  sbq[$];
    int    n_total = 0;
    int    n_bad   = 0;

    // Reference model: word text buffer plus committed counts per instance.
    string m_word;
    int    m_cnt[2];
    bit    m_err[2];
    bit    m_ovf[2];
    int    m_max[2] = '{15, 3};

    function automatic void model_reset();
        m_word = "";
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_err[i] = 1'b0;
            m_ovf[i] = 1'b0;
        end
    endfunction

    function automatic logic [6:0] model_eff(int i);
        int d;
        bit e, o, r;
        d = m_cnt[i];
        e = m_err[i];
        o = m_ovf[i];
        if (m_word == "begin") begin
            if (d == m_max[i]) o = 1'b1;
            else               d = d + 1;
        end else if (m_word == "end") begin
            if (d == 0) e = 1'b1;
            else        d = d - 1;
        end
        r = (d == 0) && !e && !o;
        return {r, d[3:0], e, o};
    endfunction

    function automatic void model_step(byte ch, bit v, bit c);
        byte lc;
        if (c) begin
            model_reset();
        end else if (v) begin
            if (ch == 8'h20) begin
                for (int i = 0; i < 2; i++) begin
                    if (m_word == "begin") begin
                        if (m_cnt[i] == m_max[i]) m_ovf[i] = 1'b1;
                        else                      m_cnt[i]++;
                    end else if (m_word == "end") begin
                        if (m_cnt[i] == 0) m_err[i] = 1'b1;
                        else               m_cnt[i]--;
                    end
                end
                m_word = "";
            end else begin
                lc = (ch >= 8'h41 && ch <= 8'h5a) ? (ch + 8'd32) : ch;
                m_word = $sformatf("%s%c", m_word, lc);
            end
        end
    endfunction

    // Drive one cycle, push the post-edge expectation, then settle past the edge.
    task automatic send(input byte ch, input bit v, input bit c);
        exp_t ex;
        @(negedge clk);
        in       = ch;
        in_valid = v;
        clear    = c;
        model_step(ch, v, c);
        ex.v0 = model_eff(0);
        ex.v1 = model_eff(1);
        sbq.push_back(ex);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    // mask: '1' accepted, '0' in_valid low, 'c' synchronous clear.
    task automatic test_basic();
        string s = "BEGIN eNd ";
        exp_t  ex;
        for (int k = 0; k < s.len(); k++) begin
            send(s[k], 1'b1, 1'b0);
            ex = sbq.pop_front();
            n_total++;
            if ({result0, depth0, error0, overflow0} !== ex.v0 ||
                {result1, 2'b00, depth1, error1, overflow1} !== ex.v1) begin
                n_bad++;
                $display("FAIL basic[%0d] got w4=%b w2=%b want w4=%b w2=%b", k,
                         {result0, depth0, error0, overflow0},
                         {result1, 2'b00, depth1, error1, overflow1}, ex.v0, ex.v1);
            end
        end
    endtask

    task automatic run_table(input string tag, input string s, input string mask);
        exp_t ex;
        byte  mk;
        for (int k = 0; k < s.len(); k++) begin
            mk = mask[k];
            send(s[k], mk == "1", mk == "c");
            ex = sbq.pop_front();
            n_total++;
            if ({result0, depth0, error0, overflow0} !== ex.v0 ||
                {result1, 2'b00, depth1, error1, overflow1} !== ex.v1) begin
                n_bad++;
                $display("FAIL %s[%0d] got w4=%b w2=%b want w4=%b w2=%b", tag, k,
                         {result0, depth0, error0, overflow0},
                         {result1, 2'b00, depth1, error1, overflow1}, ex.v0, ex.v1);
            end
        end
    endtask

    task automatic test_reset();
        n_total++;
        if ({result0, depth0, error0, overflow0} !== 7'b1_0000_00 ||
            {result1, depth1, error1, overflow1} !== 5'b1_00_00) begin
            n_bad++;
            $display("FAIL reset got w4=%b w2=%b want w4=1000000 w2=10000",
                     {result0, depth0, error0, overflow0}, {result1, depth1, error1, overflow1});
        end
    endtask

    task automatic test_retract();
        run_table("retract", "xbegins xend ending be gin ", "c11111111111111111111111111");
        n_total++;
        if (error0 !== 1'b0 || result0 !== 1'b1) begin
            n_bad++;
            $display("FAIL retract_final got err=%b res=%b want err=0 res=1", error0, result0);
        end
    endtask

    task automatic test_overflow();
        run_table("overflow", "xbegin begin begin begin end end end ",
                  "c111111111111111111111111111111111111");
        n_total++;
        if (overflow1 !== 1'b1 || depth1 !== 2'd0 || result1 !== 1'b0 || depth0 !== 4'd1) begin
            n_bad++;
            $display("FAIL overflow_final got ovf=%b d2=%0d res=%b d4=%0d want 1 0 0 1",
                     overflow1, depth1, result1, depth0);
        end
    endtask

    task automatic test_underflow();
        run_table("underflow", "xendx end xx", "c1111111111c");
        n_total++;
        if (result0 !== 1'b1 || error0 !== 1'b0 || error1 !== 1'b0) begin
            n_bad++;
            $display("FAIL underflow_clear got res=%b err=%b want res=1 err=0", result0, error0);
        end
    endtask

    task automatic test_valid_gap();
        run_table("valid_gap", "xbexxxxxgin xbxegin", "c110000011111c1c1111");
        n_total++;
        if (depth0 !== 4'd0 || result0 !== 1'b1) begin
            n_bad++;
            $display("FAIL valid_gap_final got depth=%0d res=%b want depth=0 res=1", depth0, result0);
        end
    endtask

    task automatic test_back_to_back();
        run_table("back_to_back", "xBeGiN bEgIn\tx BEGIN  END eNd end END ",
                  "c11111111111111111111111111111111111111");
    endtask

    task automatic test_async_reset();
        run_table("async_pre", "xbegin begin", "c11111111111");
        n_total++;
        if (depth0 !== 4'd2 || result0 !== 1'b0) begin
            n_bad++;
            $display("FAIL async_pre got depth=%0d res=%b want depth=2 res=0", depth0, result0);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_total++;
        if ({result0, depth0, error0, overflow0} !== 7'b1_0000_00 ||
            {result1, depth1, error1, overflow1} !== 5'b1_00_00) begin
            n_bad++;
            $display("FAIL async_reset got w4=%b w2=%b want w4=1000000 w2=10000",
                     {result0, depth0, error0, overflow0}, {result1, depth1, error1, overflow1});
        end
        model_reset();
        #7;
        reset = 1'b1;
        run_table("async_post", "end ", "1111");
    endtask

    initial begin
        reset    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in       = 8'h00;
        model_reset();
        #23;
        test_reset();
        reset = 1'b1;
        test_basic();
        test_retract();
        test_overflow();
        test_underflow();
        test_valid_gap();
        test_back_to_back();
        test_async_reset();
        n_total++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover got %0d want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
